// File: rtl/seven_seg_bin_display_pkg.sv
// Shared types and constants for the binary-to-7-segment display driver.
package seven_seg_pkg;

   // Segment word, bit order {G,F,E,D,C,B,A}, active low (0 = lit)
   typedef logic [6:0] seg_t;

   localparam seg_t SEG_DIGIT [0:9] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };
   localparam seg_t SEG_BLANK = 7'b1111111;
   localparam seg_t SEG_DASH  = 7'b0111111;

   typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

   // Largest value that fits on the given number of decimal digits (10**digits - 1)
   function automatic logic [63:0] max_shown(input int digits);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < digits; i++) begin
         p = p * 64'd10;
      end
      return p - 64'd1;
   endfunction

   // Double-dabble correction: a BCD nibble of 5 or more gets +3 before the shift
   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

endpackage

// File: rtl/seven_seg_bin_display_decoder.sv
// One BCD digit to active-low segment pattern; dash wins over blank, codes 10..15 show blank.
module seven_seg_decoder
   import seven_seg_pkg::*;
(
   input  logic [3:0] bcd_i,
   input  logic       blank_i,
   input  logic       dash_i,
   output seg_t       seg_o
);

   // Pick dash, blank or the digit glyph
   always_comb begin
      seg_o = SEG_BLANK;
      if (dash_i) begin
         seg_o = SEG_DASH;
      end else if (!blank_i) begin
         case (bcd_i)
            4'd0:    seg_o = SEG_DIGIT[0];
            4'd1:    seg_o = SEG_DIGIT[1];
            4'd2:    seg_o = SEG_DIGIT[2];
            4'd3:    seg_o = SEG_DIGIT[3];
            4'd4:    seg_o = SEG_DIGIT[4];
            4'd5:    seg_o = SEG_DIGIT[5];
            4'd6:    seg_o = SEG_DIGIT[6];
            4'd7:    seg_o = SEG_DIGIT[7];
            4'd8:    seg_o = SEG_DIGIT[8];
            4'd9:    seg_o = SEG_DIGIT[9];
            default: seg_o = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/seven_seg_bin_display.sv
// Binary value -> DIGITS active-low 7-segment groups via a one-bit-per-clock double-dabble engine.
module seven_seg_bin_display
   import seven_seg_pkg::*;
#(
   parameter int DATA_W = 6,
   parameter int DIGITS = 2
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_value,
   input  logic                  in_blank_lz,
   output logic [DIGITS*7-1:0]   seg,
   output logic                  ovf,
   output logic                  out_valid
);

   localparam int          BCD_W   = DIGITS * 4;
   localparam int          CNT_W   = $clog2(DATA_W + 1);
   localparam logic [63:0] MAX_VAL = max_shown(DIGITS);

   state_t                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [DATA_W-1:0]      shift_q;
   logic [BCD_W-1:0]       bcd_q;
   logic                   blank_lz_q;
   logic                   ovf_next_q;
   logic [DIGITS*7-1:0]    seg_q;
   logic                   ovf_q;
   logic                   out_valid_q;

   logic [BCD_W-1:0]       bcd_adj;
   logic [BCD_W-1:0]       bcd_d;
   logic [DATA_W-1:0]      shift_d;
   logic [DIGITS:0]        nz_from;
   logic [DIGITS-1:0]      blank_mask;
   logic [DIGITS*7-1:0]    seg_dec;

   // Nibble correction, leading-zero detection and per-digit decode
   assign nz_from[DIGITS] = 1'b0;
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign bcd_adj[4*gi +: 4] = add3(bcd_q[4*gi +: 4]);
      // nz_from[i]: some digit at position i or above is nonzero
      assign nz_from[gi] = nz_from[gi+1] | (|bcd_q[4*gi +: 4]);
      if (gi == 0) begin : g_units
         assign blank_mask[gi] = 1'b0;
      end else begin : g_upper
         assign blank_mask[gi] = blank_lz_q & ~nz_from[gi];
      end
      seven_seg_decoder u_dec (
         .bcd_i   (bcd_q[4*gi +: 4]),
         .blank_i (blank_mask[gi]),
         .dash_i  (ovf_next_q),
         .seg_o   (seg_dec[7*gi +: 7])
      );
   end

   // One double-dabble step: corrected BCD and binary shift left together; top BCD bit falls off
   assign bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[DATA_W-1]};
   assign shift_d = shift_q << 1;

   assign in_ready  = (state_q == IDLE) && !rst;
   assign seg       = seg_q;
   assign ovf       = ovf_q;
   assign out_valid = out_valid_q;

   // Control FSM with conversion datapath and registered display outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         bcd_q       <= '0;
         blank_lz_q  <= 1'b0;
         ovf_next_q  <= 1'b0;
         seg_q       <= '1;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready) begin
                  state_q    <= CONV;
                  shift_q    <= in_value;
                  bcd_q      <= '0;
                  cnt_q      <= CNT_W'(DATA_W - 1);
                  blank_lz_q <= in_blank_lz;
                  ovf_next_q <= (64'(in_value) > MAX_VAL);
               end
            end
            CONV: begin
               shift_q <= shift_d;
               bcd_q   <= bcd_d;
               if (cnt_q == '0) begin
                  state_q <= LOAD;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            LOAD: begin
               seg_q       <= seg_dec;
               ovf_q       <= ovf_next_q;
               out_valid_q <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seven_seg_bin_display.sv
// Self-checking bench: four display drivers of different sizes, scoreboard per instance.
module tb_seven_seg_bin_display;

   localparam int NI = 4;
   localparam int DW_T [NI] = '{6, 8, 8, 1};
   localparam int DG_T [NI] = '{2, 3, 2, 1};
   localparam logic [6:0] GLYPH [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };
   localparam logic [6:0] G_BLANK = 7'b1111111;
   localparam logic [6:0] G_DASH  = 7'b0111111;

   typedef struct {
      logic [69:0] seg;
      logic        ovf;
      int          t;
      int          v;
   } exp_t;

   logic          clk;
   logic          rst;
   logic [NI-1:0] vld;
   logic [NI-1:0] lzb;
   logic [NI-1:0] rdy;
   logic [NI-1:0] busy;
   logic [31:0]   val [NI];

   int n_checks = 0;
   int n_errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference display image built from decimal arithmetic
   function automatic logic [69:0] exp_seg(input int v, input bit lz, input int dg, output logic o);
      logic [69:0] r;
      longint      lim;
      int          d [10];
      int          msd;
      int          x;
      r   = '0;
      lim = 1;
      for (int i = 0; i < dg; i++) lim = lim * 10;
      o = (longint'(v) > lim - 1);
      x = v;
      msd = 0;
      for (int i = 0; i < dg; i++) begin
         d[i] = x % 10;
         x = x / 10;
         if (d[i] != 0) msd = i;
      end
      for (int i = 0; i < dg; i++) begin
         if (o)                        r[7*i +: 7] = G_DASH;
         else if (lz && i > msd)       r[7*i +: 7] = G_BLANK;
         else                          r[7*i +: 7] = GLYPH[d[i]];
      end
      return r;
   endfunction

   for (genvar gi = 0; gi < NI; gi++) begin : g_inst
      localparam int DW = DW_T[gi];
      localparam int DG = DG_T[gi];
      logic [DG*7-1:0] seg_l;
      logic            ovf_l;
      logic            ov_l;
      logic            rdy_l;
      exp_t            q[$];
      int              pend = 0;
      int              cyc = 0;
      int              last_ov = -1;
      int              gap = 0;
      bit              started = 0;
      bit              rst_s = 0;
      logic [69:0]     hold;
      logic            hold_ovf;

      seven_seg_bin_display #(.DATA_W(DW), .DIGITS(DG)) u_dut (
         .clk         (clk),
         .rst         (rst),
         .in_valid    (vld[gi]),
         .in_ready    (rdy_l),
         .in_value    (val[gi][DW-1:0]),
         .in_blank_lz (lzb[gi]),
         .seg         (seg_l),
         .ovf         (ovf_l),
         .out_valid   (ov_l)
      );

      assign rdy[gi]  = rdy_l;
      assign busy[gi] = (pend != 0);

      // Push expectations on accepted transfers, compare on the falling edge
      initial forever begin
         @(posedge clk or negedge clk);
         if (clk) begin
            cyc++;
            rst_s = rst;
            if (rst) begin
               q.delete();
               pend = 0;
               hold = '0;
               hold[DG*7-1:0] = '1;
               hold_ovf = 1'b0;
               started = 1;
            end else if (vld[gi] && rdy_l) begin
               exp_t e;
               e.v   = int'(val[gi][DW-1:0]);
               e.seg = exp_seg(e.v, lzb[gi], DG, e.ovf);
               e.t   = cyc;
               q.push_back(e);
               pend++;
            end
         end else if (started) begin
            if (rst_s) begin
               check($sformatf("dut%0d rst in_ready", gi), 70'(rdy_l), 70'(0));
               check($sformatf("dut%0d rst out_valid", gi), 70'(ov_l), 70'(0));
               check($sformatf("dut%0d rst ovf", gi), 70'(ovf_l), 70'(0));
               check($sformatf("dut%0d rst seg", gi), 70'(seg_l), hold);
            end else if (ov_l) begin
               if (q.size() == 0) begin
                  check($sformatf("dut%0d spurious out_valid", gi), 70'(1), 70'(0));
               end else begin
                  exp_t e;
                  e = q.pop_front();
                  pend--;
                  $display("dut%0d value=%0d seg=%h ovf=%0d latency=%0d", gi, e.v, seg_l, ovf_l, cyc - e.t);
                  check($sformatf("dut%0d seg v=%0d", gi, e.v), 70'(seg_l), e.seg);
                  check($sformatf("dut%0d ovf v=%0d", gi, e.v), 70'(ovf_l), 70'(e.ovf));
                  check($sformatf("dut%0d latency v=%0d", gi, e.v), 70'(cyc - e.t), 70'(DW + 1));
                  hold = e.seg;
                  hold_ovf = e.ovf;
               end
               if (last_ov >= 0) gap = cyc - last_ov;
               last_ov = cyc;
            end else begin
               check($sformatf("dut%0d hold seg", gi), 70'(seg_l), hold);
               check($sformatf("dut%0d hold ovf", gi), 70'(ovf_l), 70'(hold_ovf));
            end
         end
      end
   end

   // Offer a value; returns one cycle after the accepting edge
   task automatic send(input int k, input int v, input bit lz, input bit keep);
      int n;
      vld[k] = 1'b1;
      val[k] = 32'(v);
      lzb[k] = lz;
      n = 0;
      while (!rdy[k] && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 200) check("ready timeout", 70'(0), 70'(1));
      @(negedge clk);
      #1;
      if (!keep) vld[k] = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy != '0 && n < 500) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 500) check("drain timeout", 70'(busy), 70'(0));
      repeat (2) @(negedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      vld = '0;
      lzb = '0;
      for (int i = 0; i < NI; i++) val[i] = '0;
      repeat (3) @(negedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("ready after rst", 70'(rdy), 70'({NI{1'b1}}));

      // Basic conversions and boundaries
      send(0, 63, 1'b0, 1'b0);
      send(0, 0, 1'b0, 1'b0);
      send(0, 5, 1'b1, 1'b0);
      send(1, 5, 1'b1, 1'b0);
      send(1, 0, 1'b1, 1'b0);
      send(1, 120, 1'b1, 1'b0);
      send(1, 7, 1'b0, 1'b0);
      send(1, 255, 1'b0, 1'b0);
      send(2, 100, 1'b0, 1'b0);
      send(2, 99, 1'b0, 1'b0);
      send(2, 100, 1'b1, 1'b0);
      send(2, 255, 1'b1, 1'b0);
      send(2, 9, 1'b1, 1'b0);
      send(3, 1, 1'b0, 1'b0);
      send(3, 0, 1'b1, 1'b0);
      send(3, 1, 1'b1, 1'b0);
      wait_idle();

      // in_valid held across a busy period: second value waits for in_ready
      send(0, 12, 1'b0, 1'b1);
      send(0, 34, 1'b0, 1'b0);
      wait_idle();
      check("pulse gap", 70'(g_inst[0].gap), 70'(8));

      // Reset in the middle of a conversion
      send(0, 37, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("ready after mid rst", 70'(rdy[0]), 70'(1));
      send(0, 42, 1'b0, 1'b0);
      wait_idle();

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
